// File: rtl/bus_pkg.sv
// Shared bus definitions: master FSM states, bus widths and rw encoding.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2
  } bus_mst_state_e;

  localparam int BUS_ADDR_W = 30;
  localparam int BUS_DATA_W = 32;

  localparam logic BUS_RW_READ  = 1'b1;
  localparam logic BUS_RW_WRITE = 1'b0;

endpackage

// File: rtl/bus_master_if.sv
// Per-master bus interface: turns a single-word core access into
// request / grant / address phase / ready / release on the shared bus.
module bus_master_if
  import bus_pkg::*;
#(
  parameter int ADDR_W      = BUS_ADDR_W,
  parameter int DATA_W      = BUS_DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_i,
  input  logic              core_rw_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wr_data_i,
  output logic              core_busy_o,
  output logic              core_done_o,
  output logic              core_err_o,
  output logic [DATA_W-1:0] core_rd_data_o,
  output logic              bus_req_o,
  input  logic              bus_grnt_i,
  output logic              bus_as_o,
  output logic              bus_rw_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wr_data_o,
  input  logic              bus_rdy_i,
  input  logic [DATA_W-1:0] bus_rd_data_i
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  bus_mst_state_e    state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              bus_req_q;
  logic              bus_as_q;
  logic              done_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bus_req_q <= 1'b0;
      bus_as_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        // Grant is ignored here: the arbiter parks it on its last owner.
        IDLE: begin
          if (core_req_i) begin
            rw_q      <= core_rw_i;
            addr_q    <= core_addr_i;
            wdata_q   <= core_wr_data_i;
            bus_req_q <= 1'b1;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (bus_grnt_i) begin
            bus_as_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          if (bus_grnt_i && bus_rdy_i) begin
            if (rw_q == BUS_RW_READ) rdata_q <= bus_rd_data_i;
            done_q    <= 1'b1;
            bus_as_q  <= 1'b0;
            bus_req_q <= 1'b0;
            state_q   <= IDLE;
          end else if (!bus_grnt_i) begin
            bus_as_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= REQ;
          end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST)) begin
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            bus_as_q  <= 1'b0;
            bus_req_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bus fields are forced to zero outside the address phase so masters can be OR-combined.
  assign bus_rw_o      = bus_as_q & rw_q;
  assign bus_addr_o    = bus_as_q ? addr_q  : '0;
  assign bus_wr_data_o = bus_as_q ? wdata_q : '0;

  assign bus_req_o      = bus_req_q;
  assign bus_as_o       = bus_as_q;
  assign core_busy_o    = (state_q != IDLE);
  assign core_done_o    = done_q;
  assign core_err_o     = err_q;
  assign core_rd_data_o = rdata_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if with an output-level reference model checked every cycle.
module tb_bus_master_if;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        core_req_i = 1'b0;
  logic        core_rw_i = 1'b0;
  logic [29:0] core_addr_i = '0;
  logic [31:0] core_wr_data_i = '0;
  logic        core_busy_o, core_done_o, core_err_o;
  logic [31:0] core_rd_data_o;
  logic        bus_req_o;
  logic        bus_grnt_i = 1'b0;
  logic        bus_as_o, bus_rw_o;
  logic [29:0] bus_addr_o;
  logic [31:0] bus_wr_data_o;
  logic        bus_rdy_i = 1'b0;
  logic [31:0] bus_rd_data_i = '0;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  bus_master_if #(.ADDR_W(30), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .core_req_i(core_req_i), .core_rw_i(core_rw_i),
    .core_addr_i(core_addr_i), .core_wr_data_i(core_wr_data_i),
    .core_busy_o(core_busy_o), .core_done_o(core_done_o),
    .core_err_o(core_err_o), .core_rd_data_o(core_rd_data_o),
    .bus_req_o(bus_req_o), .bus_grnt_i(bus_grnt_i),
    .bus_as_o(bus_as_o), .bus_rw_o(bus_rw_o),
    .bus_addr_o(bus_addr_o), .bus_wr_data_o(bus_wr_data_o),
    .bus_rdy_i(bus_rdy_i), .bus_rd_data_i(bus_rd_data_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model. The interface phase is inferred from the expected
  // request/strobe outputs themselves: no request = idle, request without
  // strobe = waiting for grant, strobe = address phase.
  bit          e_req, e_as, e_done, e_err, l_rw;
  logic [29:0] l_addr;
  logic [31:0] l_wdata, e_rdata;
  int          as_run;

  always @(posedge clk) begin
    if (rst_i) begin
      e_req = 0; e_as = 0; e_done = 0; e_err = 0; e_rdata = '0;
      l_rw = 0; l_addr = '0; l_wdata = '0; as_run = 0;
    end else begin
      e_done = 0; e_err = 0;
      if (!e_req) begin
        if (core_req_i) begin
          l_rw = core_rw_i; l_addr = core_addr_i; l_wdata = core_wr_data_i;
          e_req = 1;
        end
      end else if (!e_as) begin
        if (bus_grnt_i) begin e_as = 1; as_run = 0; end
      end else if (bus_grnt_i && bus_rdy_i) begin
        if (l_rw) e_rdata = bus_rd_data_i;
        e_done = 1; e_as = 0; e_req = 0;
      end else if (!bus_grnt_i) begin
        e_as = 0; as_run = 0;
      end else if (TO != 0 && as_run + 1 == TO) begin
        e_done = 1; e_err = 1; e_as = 0; e_req = 0;
      end else begin
        as_run++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_done",  32'(core_done_o), 32'(e_done));
      chk("m_err",   32'(core_err_o),  32'(e_err));
      chk("m_rdata", core_rd_data_o,   e_rdata);
      chk("m_req",   32'(bus_req_o),   32'(e_req));
      chk("m_as",    32'(bus_as_o),    32'(e_as));
      chk("m_busy",  32'(core_busy_o), 32'(e_req | e_as));
      chk("m_rw",    32'(bus_rw_o),    32'(e_as & l_rw));
      chk("m_addr",  32'(bus_addr_o),  e_as ? 32'(l_addr) : 32'd0);
      chk("m_wdata", bus_wr_data_o,    e_as ? l_wdata : 32'd0);
    end
  end

  // Presents a request for one edge; returns at the first cycle in REQ.
  task automatic start(input logic rw, input logic [29:0] a, input logic [31:0] wd);
    core_req_i = 1'b1; core_rw_i = rw; core_addr_i = a; core_wr_data_i = wd;
    @(negedge clk);
    core_req_i = 1'b0;
  endtask

  int n_as;
  bit seen_done;

  initial begin
    // reset
    @(negedge clk); @(negedge clk);
    chk_en = 1'b1;
    chk("rst_done",  32'(core_done_o), 32'd0);
    chk("rst_req",   32'(bus_req_o),   32'd0);
    chk("rst_rdata", core_rd_data_o,   32'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // 1: basic read, textbook latency
    start(1'b1, 30'h100, 32'h0);
    chk("t1_req_T1", 32'(bus_req_o), 32'd1);
    chk("t1_as_T1",  32'(bus_as_o),  32'd0);
    bus_grnt_i = 1'b1;
    @(negedge clk);
    chk("t1_as_T3",   32'(bus_as_o),   32'd1);
    chk("t1_addr_T3", 32'(bus_addr_o), 32'h100);
    chk("t1_rw_T3",   32'(bus_rw_o),   32'd1);
    bus_rdy_i = 1'b1; bus_rd_data_i = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_done_T4",  32'(core_done_o), 32'd1);
    chk("t1_err_T4",   32'(core_err_o),  32'd0);
    chk("t1_rdata_T4", core_rd_data_o,   32'hDEADBEEF);
    chk("t1_req_T4",   32'(bus_req_o),   32'd0);
    chk("t1_as_T4",    32'(bus_as_o),    32'd0);
    bus_rdy_i = 1'b0; bus_rd_data_i = 32'h0;
    @(negedge clk);
    chk("t1_done_once", 32'(core_done_o), 32'd0);

    // 2: write, ready after three address-phase cycles
    chk("t2_wd_before", bus_wr_data_o, 32'd0);
    start(1'b0, 30'h2A, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_wd_access", bus_wr_data_o, 32'h12345678);
      chk("t2_rw_access", 32'(bus_rw_o), 32'd0);
    end
    bus_rdy_i = 1'b1;
    @(negedge clk);
    bus_rdy_i = 1'b0;
    chk("t2_done",      32'(core_done_o), 32'd1);
    chk("t2_rdata_keep", core_rd_data_o,  32'hDEADBEEF);
    chk("t2_wd_after",  bus_wr_data_o,    32'd0);
    @(negedge clk);
    chk("t2_done_once", 32'(core_done_o), 32'd0);

    // 3: grant withheld for five cycles
    bus_grnt_i = 1'b0;
    start(1'b1, 30'h3, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("t3_req_hold", 32'(bus_req_o),  32'd1);
      chk("t3_as_low",   32'(bus_as_o),   32'd0);
      chk("t3_addr_0",   32'(bus_addr_o), 32'd0);
      @(negedge clk);
    end
    bus_grnt_i = 1'b1;
    @(negedge clk);
    chk("t3_as_after", 32'(bus_as_o), 32'd1);
    bus_rdy_i = 1'b1; bus_rd_data_i = 32'hCAFEF00D;
    @(negedge clk);
    bus_rdy_i = 1'b0;
    chk("t3_rdata", core_rd_data_o, 32'hCAFEF00D);

    // 4a: timeout with ready never asserted
    start(1'b1, 30'h44, 32'h0);
    n_as = 0; seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (core_done_o) begin seen_done = 1; break; end
      if (bus_as_o) n_as++;
    end
    chk("t4_seen_done", 32'(seen_done), 32'd1);
    chk("t4_as_cycles", 32'(n_as), 32'd16);
    chk("t4_err",       32'(core_err_o), 32'd1);
    chk("t4_req",       32'(bus_req_o), 32'd0);
    chk("t4_rdata",     core_rd_data_o, 32'hCAFEF00D);
    @(negedge clk);

    // 4b: ready on the 16th cycle beats the timeout
    start(1'b1, 30'h45, 32'h0);
    n_as = 0; seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (core_done_o) begin seen_done = 1; break; end
      if (bus_as_o) begin
        n_as++;
        if (n_as == 16) begin bus_rdy_i = 1'b1; bus_rd_data_i = 32'h0000A5A5; end
      end
    end
    bus_rdy_i = 1'b0;
    chk("t4b_seen_done", 32'(seen_done), 32'd1);
    chk("t4b_err",       32'(core_err_o), 32'd0);
    chk("t4b_rdata",     core_rd_data_o, 32'h0000A5A5);
    @(negedge clk);

    // 5: grant dropped in the 2nd access cycle, counter restarts
    start(1'b0, 30'h55, 32'h0BADF00D);
    @(negedge clk);
    @(negedge clk);
    chk("t5_as_c2", 32'(bus_as_o), 32'd1);
    bus_grnt_i = 1'b0;
    @(negedge clk);
    chk("t5_as_drop", 32'(bus_as_o),  32'd0);
    chk("t5_req_hold", 32'(bus_req_o), 32'd1);
    chk("t5_no_done", 32'(core_done_o), 32'd0);
    bus_grnt_i = 1'b1;
    n_as = 0; seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (core_done_o) begin seen_done = 1; break; end
      if (bus_as_o) begin
        n_as++;
        if (n_as == 16) bus_rdy_i = 1'b1;
      end
    end
    bus_rdy_i = 1'b0;
    chk("t5_seen_done", 32'(seen_done), 32'd1);
    chk("t5_as_cycles", 32'(n_as), 32'd16);
    chk("t5_err",       32'(core_err_o), 32'd0);
    @(negedge clk);

    // 6: reset during access, then a normal read
    start(1'b1, 30'h66, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("t6_req",   32'(bus_req_o),   32'd0);
    chk("t6_as",    32'(bus_as_o),    32'd0);
    chk("t6_done",  32'(core_done_o), 32'd0);
    chk("t6_busy",  32'(core_busy_o), 32'd0);
    chk("t6_rdata", core_rd_data_o,   32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_done", 32'(core_done_o), 32'd0);
    end
    start(1'b1, 30'h77, 32'h0);
    @(negedge clk);
    bus_rdy_i = 1'b1; bus_rd_data_i = 32'h13572468;
    @(negedge clk);
    bus_rdy_i = 1'b0;
    chk("t6_done_after", 32'(core_done_o), 32'd1);
    chk("t6_rdata_after", core_rd_data_o,  32'h13572468);
    @(negedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
